// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the fan / dot-matrix sequencer.
//   state_e    : top-level FSM states (OFF, RUN)
//   palette_e  : colour palette selection (A, B)
//   SPD_*      : speed codes driven on the speed output
//   PAT_*      : pattern codes driven on P towards the dot-matrix driver
//   TMR_*      : auto-off timer preset steps, in seconds
// Helper functions keep the small rule tables in one place so the top level
// only deals with sequencing.
// ---------------------------------------------------------------------------
package matrix_pkg;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  typedef enum logic {
    PAL_A = 1'b0,
    PAL_B = 1'b1
  } palette_e;

  localparam logic [1:0] SPD_OFF  = 2'd0;
  localparam logic [1:0] SPD_LOW  = 2'd1;
  localparam logic [1:0] SPD_MID  = 2'd2;
  localparam logic [1:0] SPD_HIGH = 2'd3;

  localparam logic [2:0] PAT_OFF = 3'd0;
  localparam logic [2:0] PAT_A0  = 3'd1;
  localparam logic [2:0] PAT_A1  = 3'd2;
  localparam logic [2:0] PAT_B0  = 3'd3;
  localparam logic [2:0] PAT_B1  = 3'd4;

  localparam logic [4:0] TMR_OFF     = 5'd0;
  localparam logic [4:0] TMR_PRESET1 = 5'd10;
  localparam logic [4:0] TMR_PRESET2 = 5'd20;
  localparam logic [4:0] TMR_PRESET3 = 5'd30;

  // Timer button steps to the next preset above the current remaining time,
  // wrapping from the top preset back to "disabled". A press in the middle of
  // a countdown therefore extends to the next step instead of jumping around.
  function automatic logic [4:0] nextPreset(input logic [4:0] remain);
    logic [4:0] result;
    if (remain < TMR_PRESET1)      result = TMR_PRESET1;
    else if (remain < TMR_PRESET2) result = TMR_PRESET2;
    else if (remain < TMR_PRESET3) result = TMR_PRESET3;
    else                           result = TMR_OFF;
    return result;
  endfunction

  // Speed button rotates low -> mid -> high -> low.
  function automatic logic [1:0] nextSpeed(input logic [1:0] speed);
    logic [1:0] result;
    case (speed)
      SPD_LOW: result = SPD_MID;
      SPD_MID: result = SPD_HIGH;
      default: result = SPD_LOW;
    endcase
    return result;
  endfunction

  // Pattern code for a running display: two frames per palette.
  function automatic logic [2:0] patternFor(input palette_e pal, input logic phase);
    logic [2:0] result;
    if (pal == PAL_A) result = phase ? PAT_A1 : PAT_A0;
    else              result = phase ? PAT_B1 : PAT_B0;
    return result;
  endfunction

endpackage

// File: rtl/tick_div.sv
// ---------------------------------------------------------------------------
// tick_div
// Modulo counter used both as the frame timer and as the one-second
// prescaler. Counts 0..max_i while enabled and wraps to 0 after max_i.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, counter to 0
//   clr_i  : synchronous clear, wins over counting
//   en_i   : count enable
//   max_i  : terminal count value (modulus - 1), may change at run time
//   tc_o   : high while enabled and sitting on the terminal count, i.e. the
//            cycle whose closing edge wraps the counter
// tc_o deliberately ignores clr_i so the parent can decide which event wins
// when a clear and a terminal count coincide.
// ---------------------------------------------------------------------------
module tick_div import matrix_pkg::*; #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] max_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc_o = en_i && (count_q == max_i);

  // Next count: clear first, otherwise advance and wrap on the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/matrix_seq.sv
// ---------------------------------------------------------------------------
// matrix_seq
// Fan controller with a two-frame animated dot-matrix display and an
// auto-off countdown timer.
//   clk        : 1 kHz system clock, rising edge
//   rst_n      : asynchronous active-low reset, forces the OFF state
//   btn_power  : pulse, toggles OFF/RUN (wins over every other button)
//   btn_speed  : pulse, rotates speed 1->2->3->1 while running
//   btn_color  : pulse, swaps palette A/B while running
//   btn_timer  : pulse, steps auto-off preset 0->10->20->30->0 while running
//   P          : pattern select (0 off, 1/2 palette A, 3/4 palette B)
//   speed      : 0 off, 1 low, 2 mid, 3 high
//   running    : high in RUN
//   remain     : remaining auto-off seconds, 0 means no auto-off
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module matrix_seq import matrix_pkg::*; #(
  parameter int FRAME_LOW  = 500,
  parameter int FRAME_MID  = 250,
  parameter int FRAME_HIGH = 125,
  parameter int SEC_TICKS  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_power,
  input  logic       btn_speed,
  input  logic       btn_color,
  input  logic       btn_timer,
  output logic [2:0] P,
  output logic [1:0] speed,
  output logic       running,
  output logic [4:0] remain
);

  localparam int FRAME_MAX = (FRAME_LOW > FRAME_MID)
                             ? ((FRAME_LOW > FRAME_HIGH) ? FRAME_LOW : FRAME_HIGH)
                             : ((FRAME_MID > FRAME_HIGH) ? FRAME_MID : FRAME_HIGH);
  localparam int FW = $clog2(FRAME_MAX + 1);
  localparam int SW = $clog2(SEC_TICKS + 1);

  state_e     state_q,   state_d;
  logic [1:0] speed_q,   speed_d;
  logic       phase_q,   phase_d;
  palette_e   palette_q, palette_d;
  logic [4:0] remain_q,  remain_d;
  logic [2:0] pat_q,     pat_d;
  logic       running_q, running_d;

  logic          goOff;
  logic          speedApplied;
  logic          timerApplied;
  logic          frameTc;
  logic          frameEn;
  logic          frameClr;
  logic [FW-1:0] frameMax;
  logic          secTc;
  logic          secEn;
  logic          secClr;

  // Frame length follows the speed currently in effect; a speed change also
  // clears the counter so the new length starts from a clean frame.
  always_comb begin
    frameMax = FW'(FRAME_LOW - 1);
    case (speed_q)
      SPD_MID:  frameMax = FW'(FRAME_MID - 1);
      SPD_HIGH: frameMax = FW'(FRAME_HIGH - 1);
      default:  frameMax = FW'(FRAME_LOW - 1);
    endcase
  end

  assign frameEn  = (state_q == ST_RUN);
  assign frameClr = (state_q != ST_RUN) || goOff || speedApplied;

  // The prescaler only runs while a countdown is active and restarts a full
  // second whenever the preset is changed.
  assign secEn  = (state_q == ST_RUN) && (remain_q != TMR_OFF);
  assign secClr = !secEn || goOff || timerApplied;

  tick_div #(.WIDTH(FW)) u_frame_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (frameClr),
    .en_i  (frameEn),
    .max_i (frameMax),
    .tc_o  (frameTc)
  );

  tick_div #(.WIDTH(SW)) u_sec_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (secClr),
    .en_i  (secEn),
    .max_i (SW'(SEC_TICKS - 1)),
    .tc_o  (secTc)
  );

  // Next-state logic. Power wins over everything; timer expiry wins over the
  // remaining buttons. A speed press swallows a coincident frame boundary so
  // the phase only moves on a full frame at the new speed. A timer press wins
  // over an ordinary (non-expiring) one-second decrement.
  always_comb begin
    state_d      = state_q;
    speed_d      = speed_q;
    phase_d      = phase_q;
    palette_d    = palette_q;
    remain_d     = remain_q;
    goOff        = 1'b0;
    speedApplied = 1'b0;
    timerApplied = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (btn_power) begin
          state_d   = ST_RUN;
          speed_d   = SPD_LOW;
          phase_d   = 1'b0;
          palette_d = PAL_A;
          remain_d  = TMR_OFF;
        end
      end

      ST_RUN: begin
        if (btn_power) begin
          goOff = 1'b1;
        end else if (secTc && (remain_q == 5'd1)) begin
          goOff = 1'b1;
        end else begin
          if (btn_speed) begin
            speed_d      = nextSpeed(speed_q);
            speedApplied = 1'b1;
          end else if (frameTc) begin
            phase_d = ~phase_q;
          end

          if (btn_color) begin
            palette_d = (palette_q == PAL_A) ? PAL_B : PAL_A;
          end

          if (btn_timer) begin
            remain_d     = nextPreset(remain_q);
            timerApplied = 1'b1;
          end else if (secTc) begin
            remain_d = remain_q - 5'd1;
          end
        end

        if (goOff) begin
          state_d   = ST_OFF;
          speed_d   = SPD_OFF;
          phase_d   = 1'b0;
          palette_d = PAL_A;
          remain_d  = TMR_OFF;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Output values are derived from the next state so P, speed, running and
  // remain all change on the same edge as the state they describe.
  always_comb begin
    pat_d     = PAT_OFF;
    running_d = 1'b0;
    if (state_d == ST_RUN) begin
      pat_d     = patternFor(palette_d, phase_d);
      running_d = 1'b1;
    end
  end

  // State and output registers; reset lands directly in the OFF values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      speed_q   <= SPD_OFF;
      phase_q   <= 1'b0;
      palette_q <= PAL_A;
      remain_q  <= TMR_OFF;
      pat_q     <= PAT_OFF;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      phase_q   <= phase_d;
      palette_q <= palette_d;
      remain_q  <= remain_d;
      pat_q     <= pat_d;
      running_q <= running_d;
    end
  end

  assign P       = pat_q;
  assign speed   = speed_q;
  assign running = running_q;
  assign remain  = remain_q;

endmodule

// File: tb/tb_matrix_seq.sv
// ---------------------------------------------------------------------------
// tb_matrix_seq
// Self-checking bench for matrix_seq. A cycle-level behavioural model of the
// controller (plain integers, per-speed frame length table) runs alongside
// the DUT; directed scenarios are followed by a randomized button phase.
// ---------------------------------------------------------------------------
module tb_matrix_seq;

  localparam int FRAME_LOW  = 500;
  localparam int FRAME_MID  = 250;
  localparam int FRAME_HIGH = 125;
  localparam int SEC_TICKS  = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnPower = 1'b0;
  logic       btnSpeed = 1'b0;
  logic       btnColor = 1'b0;
  logic       btnTimer = 1'b0;
  logic [2:0] dutP;
  logic [1:0] dutSpeed;
  logic       dutRunning;
  logic [4:0] dutRemain;

  int errorCount = 0;
  int checkCount = 0;

  int mOn, mSpeed, mPalB, mPhase, mFrameCnt, mRemain, mSecCnt;
  int frameLen [4] = '{0, FRAME_LOW, FRAME_MID, FRAME_HIGH};

  matrix_seq #(
    .FRAME_LOW  (FRAME_LOW),
    .FRAME_MID  (FRAME_MID),
    .FRAME_HIGH (FRAME_HIGH),
    .SEC_TICKS  (SEC_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_power (btnPower),
    .btn_speed (btnSpeed),
    .btn_color (btnColor),
    .btn_timer (btnTimer),
    .P         (dutP),
    .speed     (dutSpeed),
    .running   (dutRunning),
    .remain    (dutRemain)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOn = 0; mSpeed = 0; mPalB = 0; mPhase = 0;
    mFrameCnt = 0; mRemain = 0; mSecCnt = 0;
  endtask

  function automatic int modelP();
    return (mOn != 0) ? ((mPalB != 0 ? 3 : 1) + mPhase) : 0;
  endfunction

  // One clock edge of the behavioural model, given this cycle's buttons.
  task automatic modelStep(input bit pw, input bit sp, input bit co, input bit ti);
    if (mOn == 0) begin
      if (pw) begin
        mOn = 1; mSpeed = 1; mPalB = 0; mPhase = 0;
        mFrameCnt = 0; mRemain = 0; mSecCnt = 0;
      end
    end else if (pw || (mRemain == 1 && mSecCnt == SEC_TICKS - 1)) begin
      modelReset();
    end else begin
      if (sp) begin
        mSpeed = (mSpeed % 3) + 1;
        mFrameCnt = 0;
      end else if (mFrameCnt == frameLen[mSpeed] - 1) begin
        mPhase = 1 - mPhase;
        mFrameCnt = 0;
      end else begin
        mFrameCnt++;
      end
      if (co) mPalB = 1 - mPalB;
      if (ti) begin
        mRemain = (mRemain / 10 + 1) * 10;
        if (mRemain > 30) mRemain = 0;
        mSecCnt = 0;
      end else if (mRemain > 0) begin
        if (mSecCnt == SEC_TICKS - 1) begin
          mRemain--;
          mSecCnt = 0;
        end else begin
          mSecCnt++;
        end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".P"},       dutP,       modelP());
    checkOutput({tag, ".speed"},   dutSpeed,   mSpeed);
    checkOutput({tag, ".running"}, dutRunning, mOn);
    checkOutput({tag, ".remain"},  dutRemain,  mRemain);
  endtask

  // Drive one cycle of buttons, advance the model, sample after the edge.
  task automatic applyStimulus(input bit pw, input bit sp, input bit co, input bit ti);
    btnPower = pw; btnSpeed = sp; btnColor = co; btnTimer = ti;
    modelStep(pw, sp, co, ti);
    @(posedge clk);
    #1;
    btnPower = 1'b0; btnSpeed = 1'b0; btnColor = 1'b0; btnTimer = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    modelReset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset");
    rst_n = 1'b1;
    idle(2);
    checkAll("offIdle");

    // Power on and low-speed frame toggling.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("powerOn.P", dutP, 1);
    checkOutput("powerOn.speed", dutSpeed, 1);
    checkOutput("powerOn.running", dutRunning, 1);
    idle(FRAME_LOW - 1);
    checkOutput("low.beforeEdge", dutP, 1);
    idle(1);
    checkOutput("low.toggle", dutP, 2);
    idle(FRAME_LOW);
    checkOutput("low.back", dutP, 1);
    checkAll("low.model");

    // Speed rotation; high-speed frame measured from the second press.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("speed.mid", dutSpeed, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("speed.high", dutSpeed, 3);
    idle(FRAME_HIGH - 1);
    checkOutput("high.hold", dutP, 1);
    idle(1);
    checkOutput("high.toggle", dutP, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("speed.wrap", dutSpeed, 1);
    checkAll("speed.model");

    // Palette swap at phase 1, then the next frame boundary.
    checkOutput("color.pre", dutP, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("color.swap", dutP, 4);
    n = 0;
    while (dutP == 3'd4 && n < FRAME_LOW + 100) begin
      idle(1);
      n++;
    end
    checkOutput("color.boundary", dutP, 3);
    checkOutput("color.boundaryCycles", n, FRAME_LOW - 1);
    checkAll("color.model");

    // Ten-second auto-off.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("timer.set", dutRemain, 10);
    idle(SEC_TICKS * 10 - 1);
    checkOutput("timer.lastRunning", dutRunning, 1);
    checkOutput("timer.lastRemain", dutRemain, 1);
    idle(1);
    checkOutput("timer.expP", dutP, 0);
    checkOutput("timer.expRunning", dutRunning, 0);
    checkOutput("timer.expSpeed", dutSpeed, 0);
    checkOutput("timer.expRemain", dutRemain, 0);

    // Power priority and buttons ignored in OFF.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAll("prio.on");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("prio.P", dutP, 0);
    checkOutput("prio.running", dutRunning, 0);
    checkOutput("prio.speed", dutSpeed, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("offSpeed.P", dutP, 0);
    checkOutput("offSpeed.speed", dutSpeed, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkAll("offColorTimer");

    // Randomized buttons against the model.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 399) == 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 99) == 0));
      checkAll("rand");
    end

    // Asynchronous reset mid-countdown with P=4.
    if (mOn == 0) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    if (mPalB == 0) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (mRemain != 10 && n < 4) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    n = 0;
    while (!(mRemain == 7 && modelP() == 4) && n < 6000) begin
      idle(1);
      n++;
    end
    checkOutput("async.preP", dutP, 4);
    checkOutput("async.preRemain", dutRemain, 7);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async.P", dutP, 0);
    checkOutput("async.remain", dutRemain, 0);
    checkOutput("async.running", dutRunning, 0);
    checkOutput("async.speed", dutSpeed, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(FRAME_LOW + 50);
    checkAll("async.noResume");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/matrix_seq.md
MATRIX_SEQ -- requirements
Module: matrix_seq

Interface
REQ-001 FRAME_LOW, default 500, frame length in clk cycles at speed 1.
REQ-002 FRAME_MID, default 250, frame length in clk cycles at speed 2.
REQ-003 FRAME_HIGH, default 125, frame length in clk cycles at speed 3.
REQ-004 SEC_TICKS, default 1000, clk cycles per shutdown-timer second.
REQ-005 clk  input  1  1 kHz system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 btn_power  input  1  single-cycle debounced pulse; toggles power.
REQ-008 btn_speed  input  1  single-cycle pulse; cycles fan speed.
REQ-009 btn_color  input  1  single-cycle pulse; swaps palette A/B.
REQ-010 btn_timer  input  1  single-cycle pulse; cycles auto-off preset.
REQ-011 P  output  3  pattern select to dot-matrix driver: 0 off, 1/2 palette A frames, 3/4 palette B frames.
REQ-012 speed  output  2  current speed: 0 off, 1 low, 2 mid, 3 high.
REQ-013 running  output  1  high in RUN state.
REQ-014 remain  output  5  remaining auto-off seconds; 0 = timer disabled.

Function
REQ-015 FSM has two states, OFF and RUN; all outputs registered; P never takes values 5-7.
REQ-016 OFF: P=0, speed=0, running=0, remain=0, phase=0, palette=A, all counters held at 0.
REQ-017 OFF + btn_power -> RUN at next edge with speed=1, phase=0, palette=A, P=1, remain=0.
REQ-018 RUN + btn_power -> OFF at next edge; all OFF values restored the same edge.
REQ-019 btn_power has priority; other pulses in the same cycle are ignored.
REQ-020 btn_speed, btn_color, btn_timer are ignored in OFF.
REQ-021 RUN: frame counter counts 0..FRAME(speed)-1; at terminal count, phase toggles and counter returns to 0.
REQ-022 P = 1+phase for palette A, 3+phase for palette B; P updates the same edge as phase or palette changes.
REQ-023 btn_speed: speed 1->2->3->1; frame counter cleared to 0; phase unchanged.
REQ-024 btn_color: palette toggles, frame counter and phase unchanged; P changes at next edge.
REQ-025 btn_speed and btn_color in the same cycle are both applied.
REQ-026 btn_timer: remain cycles 0->10->20->30->0; second prescaler cleared on every press.
REQ-027 While remain>0, prescaler counts 0..SEC_TICKS-1; at terminal count, remain decrements.
REQ-028 remain reaching 0 by decrement forces OFF at that same edge; expiry overrides btn_speed/btn_color/btn_timer in that cycle.
REQ-029 Setting remain to 0 via btn_timer disables auto-off without leaving RUN.

Reset
REQ-030 rst_n low asynchronously forces OFF state and every OFF output value of REQ-016; release takes effect at the first clk edge with rst_n high.
REQ-031 Reset mid-frame or mid-countdown discards all counter state; no pattern resumes after release.

Structure
REQ-032 Shared package matrix_pkg holds FSM state enum, speed codes, pattern codes (PAT_OFF, PAT_A0, PAT_A1, PAT_B0, PAT_B1), timer preset steps.
REQ-033 One sub-module tick_div (parameterised modulo counter with clear, enable, terminal-count pulse), instanced for frame timer and second prescaler.

Verification
REQ-034 Reset, btn_power pulse -> P=1, speed=1, running=1; P toggles 1/2 every 500 cycles.
REQ-035 In RUN, btn_speed twice -> speed=3; P toggles every 125 cycles measured from second press; third press -> speed=1.
REQ-036 In RUN at phase 1, btn_color -> P 2->4 next edge; next frame boundary -> P=3.
REQ-037 btn_timer once -> remain=10; after 10000 cycles -> remain=0, P=0, running=0, speed=0.
REQ-038 btn_power coincident with btn_speed and btn_color in RUN -> OFF, P=0; in OFF, btn_speed alone -> no change.
REQ-039 rst_n asserted mid-countdown (remain=7, P=4) -> P=0, remain=0 immediately, without waiting for clk.
